imem_fetch_ctrl: RTL

Instruction-fetch controller for the pipelined MIPS core. It owns the program counter and drives the address and enable of the combinational instruction memory (128 words, word-addressed). It selects the next PC among sequential, jump, branch, exception, interrupt and return redirects, and registers the fetched word into the IF/ID stage with a valid bit. It also records the exception return PC (EPC) and tracks handler mode so that interrupts cannot nest.

---
 rtl/imem_fetch_pkg.sv | 35 +++
 rtl/imem_fetch_nextpc.sv | 66 ++++++
 rtl/imem_fetch_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg
// Shared definitions for the instruction-fetch controller:
//   - FSM state encodings (BOOT, RUN, HANDLER), kept as fixed legacy codes
//     and wrapped in an enum so the controller can use named states.
//   - NOP instruction word loaded into IF/ID when it is squashed.
//   - Redirect-cause enum produced by the next-PC priority mux.
//   - word_align(): forces bits [1:0] of a target to zero.
package imem_fetch_pkg;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;

    typedef enum logic [1:0] {
        BOOT    = ST_BOOT,
        RUN     = ST_RUN,
        HANDLER = ST_HANDLER
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_EXC    = 3'd1,
        CAUSE_IRQ    = 3'd2,
        CAUSE_ERET   = 3'd3,
        CAUSE_BRANCH = 3'd4,
        CAUSE_JUMP   = 3'd5
    } redirect_cause_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_nextpc.sv
// imem_fetch_nextpc
// Combinational next-PC priority mux for the fetch controller.
// Priority, highest first: exc, irq (RUN and not stalled), eret, branch,
// jump, hold (stall or BOOT), pc+4. Reset is applied by the register stage.
// Ports:
//   state_i          current controller state (imem_fetch_pkg codes)
//   pc_i / epc_i     current PC and saved return PC
//   stall_i          hold request
//   exc_i, irq_i, eret_i, branch_i, jump_i   redirect requests
//   branch_target_i / jump_target_i          redirect targets (masked here)
//   next_pc_o        PC to load on the next edge
//   redirect_o       high when any redirect is taken
//   cause_o          redirect_cause_e code of the taken redirect
module imem_fetch_nextpc
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = 32'h0000_0004,
    parameter logic [31:0] EXC_VEC = 32'h0000_0008
) (
    input  logic [1:0]  state_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] epc_i,
    input  logic        stall_i,
    input  logic        exc_i,
    input  logic        irq_i,
    input  logic        eret_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o,
    output logic [2:0]  cause_o
);

    always_comb begin
        next_pc_o  = pc_i + 32'd4;
        redirect_o = 1'b0;
        cause_o    = CAUSE_NONE;
        if (exc_i) begin
            next_pc_o  = EXC_VEC;
            redirect_o = 1'b1;
            cause_o    = CAUSE_EXC;
        end else if (irq_i && (state_i == ST_RUN) && !stall_i) begin
            next_pc_o  = IRQ_VEC;
            redirect_o = 1'b1;
            cause_o    = CAUSE_IRQ;
        end else if (eret_i) begin
            next_pc_o  = word_align(epc_i);
            redirect_o = 1'b1;
            cause_o    = CAUSE_ERET;
        end else if (branch_i) begin
            next_pc_o  = word_align(branch_target_i);
            redirect_o = 1'b1;
            cause_o    = CAUSE_BRANCH;
        end else if (jump_i) begin
            next_pc_o  = word_align(jump_target_i);
            redirect_o = 1'b1;
            cause_o    = CAUSE_JUMP;
        end else if (stall_i || (state_i == ST_BOOT)) begin
            // BOOT performs no fetch, so the PC must not advance either.
            next_pc_o  = pc_i;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch controller: owns the PC, drives the combinational
// instruction memory, registers the fetched word into IF/ID, records the
// exception return PC and tracks handler mode (no nested interrupts).
// Optional feature: define IMEM_FETCH_PERF_EN to build the saturating
// fetch/stall/flush performance counters; otherwise those ports read 0.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall_i, flush_i           hold PC+IF/ID, squash IF/ID
//   jump_*, branch_*           ID/EX redirects
//   exc_i, exc_pc_i            exception and faulting PC
//   irq_i, eret_i              level interrupt, handler return
//   imem_addr_o, imem_en_o     memory word address and enable
//   imem_instr_i               fetched word
//   if_id_instr_o/pc4_o/valid_o IF/ID stage register
//   pc_o, epc_o, in_handler_o  architectural status
//   fetch/stall/flush_cnt_o    performance counters
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int unsigned IMEM_AW   = 7,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h0000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               jump_i,
    input  logic [31:0]        jump_target_i,
    input  logic               branch_i,
    input  logic [31:0]        branch_target_i,
    input  logic               exc_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               irq_i,
    input  logic               eret_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic               imem_en_o,
    input  logic [31:0]        imem_instr_i,
    output logic [31:0]        if_id_instr_o,
    output logic [31:0]        if_id_pc4_o,
    output logic               if_id_valid_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        epc_o,
    output logic               in_handler_o,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  epc_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc4_q;
    logic         if_valid_q;

    logic [31:0]  next_pc;
    logic         redirect;
    logic [2:0]   cause;
    logic         invalidate;
    logic         fetch_load;
    logic         stall_edge;

    imem_fetch_nextpc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_nextpc (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .epc_i           (epc_q),
        .stall_i         (stall_i),
        .exc_i           (exc_i),
        .irq_i           (irq_i),
        .eret_i          (eret_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect),
        .cause_o         (cause)
    );

    // A redirect beats stall: the wrong-path word is squashed and the PC moves.
    assign invalidate = redirect || flush_i;
    assign fetch_load = !invalidate && !stall_i && (state_q != BOOT);
    assign stall_edge = stall_i && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            if_instr_q <= NOP;
            if_pc4_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            pc_q <= next_pc;

            unique case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     if (cause == CAUSE_EXC || cause == CAUSE_IRQ) state_q <= HANDLER;
                HANDLER: if (cause == CAUSE_ERET) state_q <= RUN;
                default: state_q <= BOOT;
            endcase

            // EPC is captured only on entry to the handler; a nested
            // exception keeps the original return address.
            if (state_q == RUN) begin
                if (cause == CAUSE_EXC)
                    epc_q <= exc_pc_i;
                else if (cause == CAUSE_IRQ)
                    epc_q <= pc_q;
            end

            if (invalidate) begin
                if_instr_q <= NOP;
                if_valid_q <= 1'b0;
            end else if (fetch_load) begin
                if_instr_q <= imem_instr_i;
                if_pc4_q   <= pc_q + 32'd4;
                if_valid_q <= 1'b1;
            end
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_load && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_edge && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (invalidate && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = stall_edge;
    assign fetch_cnt_o = '0;
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

    assign imem_addr_o   = pc_q[IMEM_AW+1:2];
    assign imem_en_o     = (state_q != BOOT);
    assign if_id_instr_o = if_instr_q;
    assign if_id_pc4_o   = if_pc4_q;
    assign if_id_valid_o = if_valid_q;
    assign pc_o          = pc_q;
    assign epc_o         = epc_q;
    assign in_handler_o  = (state_q == HANDLER);

endmodule
